// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the RISC sequencer.
// Holds the instruction field layout, the opcode constants, the FSM state encoding,
// the decoded-instruction payload struct and the opcode classifier.
package risc_pkg;

  // Instruction word geometry
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned DMA_W    = 4;
  localparam int unsigned RET_W    = 16;

  // Field LSB positions; src_b and dmaddr overlap on bit 3 by design
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned DST_LSB  = 9;
  localparam int unsigned SRCA_LSB = 6;
  localparam int unsigned SRCB_LSB = 3;
  localparam int unsigned DMA_LSB  = 0;

  // Opcode map: 0 nop, 1..13 ALU, 14 ld, 15 st
  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LD  = 4'hE;
  localparam logic [OPC_W-1:0] OP_ST  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_NOP = 2'd0,
    CLS_ALU = 2'd1,
    CLS_LD  = 2'd2,
    CLS_ST  = 2'd3
  } iclass_e;

  typedef struct packed {
    iclass_e          cls;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic [DMA_W-1:0] dmaddr;
  } ir_fields_t;

  // Map an opcode onto its instruction class
  function automatic iclass_e classify(input logic [OPC_W-1:0] opc);
    iclass_e cls;
    case (opc)
      OP_NOP:  cls = CLS_NOP;
      OP_LD:   cls = CLS_LD;
      OP_ST:   cls = CLS_ST;
      default: cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/risc_ir_decode.sv
// risc_ir_decode: purely combinational instruction decoder.
// Ports:
//   ir     - instruction register contents
//   fields - instruction class plus extracted opcode/dst/src_a/src_b/dmaddr
module risc_ir_decode
  import risc_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output ir_fields_t         fields
);

  // Field extraction and classification
  always_comb begin
    fields        = '0;
    fields.opcode = ir[OPC_LSB  +: OPC_W];
    fields.dst    = ir[DST_LSB  +: REG_W];
    fields.src_a  = ir[SRCA_LSB +: REG_W];
    fields.src_b  = ir[SRCB_LSB +: REG_W];
    fields.dmaddr = ir[DMA_LSB  +: DMA_W];
    fields.cls    = classify(ir[OPC_LSB +: OPC_W]);
  end

endmodule

// File: rtl/risc_seq_ctrl.sv
// risc_seq_ctrl: multi-cycle instruction sequencer for a small RISC core.
// Walks IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB), fetching one 16-bit
// instruction per pass and steering the register file and execution unit.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   run                         - enable sequencing (checked only between instructions)
//   imem_req/imem_addr          - fetch request and address (= pc)
//   imem_ack/imem_data          - fetch completion and instruction word
//   rf_rd_a/rf_rd_b             - register-file read selects (src a / src b)
//   eu_opcode/eu_dstin/eu_dmaddrin - execution-unit controls; opcode only live in EXEC
//   eu_reg_wr_vld/eu_load_op    - execution-unit status, consumed in WB
//   rf_wr_en/rf_wr_sel          - register-file write strobe and source select
//   busy                        - high whenever the FSM is not in IDLE
//   retired                     - wrapping count of completed instructions
module risc_seq_ctrl
  import risc_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [2:0]        rf_rd_a,
  output logic [2:0]        rf_rd_b,
  output logic [3:0]        eu_opcode,
  output logic [2:0]        eu_dstin,
  output logic [3:0]        eu_dmaddrin,
  input  logic              eu_reg_wr_vld,
  input  logic              eu_load_op,
  output logic              rf_wr_en,
  output logic              rf_wr_sel,
  output logic              busy,
  output logic [15:0]       retired
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [RET_W-1:0]     retired_q, retired_d;
  logic                 imem_req_q, imem_req_d;
  logic                 busy_q, busy_d;
  logic [OPC_W-1:0]     eu_opcode_q, eu_opcode_d;
  logic                 retire;
  ir_fields_t           dec;

  risc_ir_decode u_ir_decode (
    .ir     (ir_q),
    .fields (dec)
  );

  // Next-state, fetch capture and retirement
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.cls == CLS_NOP) begin
          retire  = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = (dec.cls == CLS_ALU) ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        if (dec.cls == CLS_LD) begin
          state_d = ST_WB;
        end else begin
          retire  = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    retired_d = retired_q + RET_W'(retire);
  end

  // Registered outputs are decoded from the next state so they line up with it
  always_comb begin
    imem_req_d  = (state_d == ST_FETCH);
    busy_d      = (state_d != ST_IDLE);
    eu_opcode_d = (state_d == ST_EXEC) ? dec.opcode : OP_NOP;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      retired_q   <= '0;
      imem_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      eu_opcode_q <= OP_NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      imem_req_q  <= imem_req_d;
      busy_q      <= busy_d;
      eu_opcode_q <= eu_opcode_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign busy        = busy_q;
  assign eu_opcode   = eu_opcode_q;
  assign retired     = retired_q;

  // IR fields are held stable from DECODE until the next fetch completes
  assign rf_rd_a     = dec.src_a;
  assign rf_rd_b     = dec.src_b;
  assign eu_dstin    = dec.dst;
  assign eu_dmaddrin = dec.dmaddr;

  // Write strobe qualifies same-cycle execution-unit status, so it stays combinational
  assign rf_wr_en    = (state_q == ST_WB) && (eu_reg_wr_vld || eu_load_op);
  assign rf_wr_sel   = (state_q == ST_WB) && eu_load_op;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// tb_risc_seq_ctrl: directed scoreboard bench for risc_seq_ctrl.
// The driver plays instruction memory and the execution unit, pushing the expected
// fetch/exec/write/retire events; a negedge monitor pops and compares them,
// including each event's cycle offset from the fetch acknowledge.
module tb_risc_seq_ctrl;

  localparam int unsigned PC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [2:0]      rf_rd_a, rf_rd_b, eu_dstin;
  logic [3:0]      eu_opcode, eu_dmaddrin;
  logic            eu_reg_wr_vld, eu_load_op;
  logic            rf_wr_en, rf_wr_sel, busy;
  logic [15:0]     retired;

  risc_seq_ctrl #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .rf_rd_a       (rf_rd_a),
    .rf_rd_b       (rf_rd_b),
    .eu_opcode     (eu_opcode),
    .eu_dstin      (eu_dstin),
    .eu_dmaddrin   (eu_dmaddrin),
    .eu_reg_wr_vld (eu_reg_wr_vld),
    .eu_load_op    (eu_load_op),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_sel     (rf_wr_sel),
    .busy          (busy),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum int {EV_FETCH, EV_EXEC, EV_WR, EV_RET} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] val;
    int          ofs;
  } ev_t;

  ev_t         sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_pc  = 8'h00;
  logic [15:0] exp_ret = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [15:0] v, input int ofs);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.ofs  = ofs;
    sb.push_back(e);
  endtask

  task automatic sb_check(input ev_kind_e k, input logic [15:0] v, input int ofs);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_%s: got val=%0h ofs=%0d want no event (t=%0t)", k.name(), v, ofs, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val !== v || e.ofs != ofs) begin
        bad++;
        $display("FAIL sb_%s: got %s val=%0h ofs=%0d want %s val=%0h ofs=%0d (t=%0t)",
                 e.kind.name(), k.name(), v, ofs, e.kind.name(), e.val, e.ofs, $time);
      end
    end
  endtask

  // Monitor: retire is checked first since it can share a cycle with the next fetch
  int          fetch_cyc = 0;
  logic [15:0] prev_ret  = 16'h0000;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ret = retired;
    end else begin
      if (retired !== prev_ret) begin
        sb_check(EV_RET, retired, cyc - fetch_cyc);
        prev_ret = retired;
      end
      if (rf_wr_en)
        sb_check(EV_WR, 16'(rf_wr_sel), cyc - fetch_cyc);
      if (eu_opcode != 4'h0)
        sb_check(EV_EXEC, 16'(eu_opcode), cyc - fetch_cyc);
      if (imem_req && imem_ack) begin
        fetch_cyc = cyc;
        sb_check(EV_FETCH, 16'(imem_addr), 0);
      end
    end
  end

  // Serve one instruction: wait for the fetch, optionally stall, ack, push expectations
  task automatic do_instr(input logic [15:0] w, input int dly, input bit wr_vld,
                          input bit drop_run, input bit junk_ack, input bit abort);
    logic [3:0] opc;
    bit         got;
    bit         is_nop, is_ld, is_st, is_alu;
    opc    = w[15:12];
    is_nop = (opc == 4'h0);
    is_ld  = (opc == 4'hE);
    is_st  = (opc == 4'hF);
    is_alu = !is_nop && !is_ld && !is_st;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (imem_req) got = 1'b1;
    end
    imem_ack = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: got imem_req=0 want 1 within 20 cycles (t=%0t)", $time);
      return;
    end
    for (int d = 0; d < dly; d++) begin
      chk("stall_req",  32'(imem_req),  32'h1);
      chk("stall_addr", 32'(imem_addr), 32'(exp_pc));
      chk("stall_opc",  32'(eu_opcode), 32'h0);
      @(posedge clk); #1;
    end
    push(EV_FETCH, 16'(exp_pc), 0);
    if (!is_nop) push(EV_EXEC, 16'(opc), 2);
    if (!abort) begin
      if (is_alu && wr_vld) push(EV_WR, 16'h0000, 3);
      if (is_ld)            push(EV_WR, 16'h0001, 4);
      exp_ret++;
      push(EV_RET, exp_ret, is_nop ? 2 : (is_ld ? 5 : 4));
    end
    exp_pc++;
    imem_ack      = 1'b1;
    imem_data     = w;
    eu_load_op    = is_ld;
    eu_reg_wr_vld = wr_vld;
    @(posedge clk); #1;
    imem_ack  = 1'b0;
    imem_data = 16'hFFFF;
    if (drop_run) run = 1'b0;
    if (!is_nop) begin
      chk("dec_rd_a",  32'(rf_rd_a),     32'(w[8:6]));
      chk("dec_rd_b",  32'(rf_rd_b),     32'(w[5:3]));
      chk("dec_dst",   32'(eu_dstin),    32'(w[11:9]));
      chk("dec_dmadr", 32'(eu_dmaddrin), 32'(w[3:0]));
    end
    // Spurious acks outside FETCH must not disturb sequencing
    if (junk_ack) imem_ack = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},  32'(imem_req),  32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
    chk({tag, "_busy"}, 32'(busy),      32'h0);
    chk({tag, "_wren"}, 32'(rf_wr_en),  32'h0);
    chk({tag, "_wsel"}, 32'(rf_wr_sel), 32'h0);
    chk({tag, "_opc"},  32'(eu_opcode), 32'h0);
    chk({tag, "_ret"},  32'(retired),   32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst");
    exp_pc  = 8'h00;
    exp_ret = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    run           = 1'b0;
    imem_ack      = 1'b0;
    imem_data     = 16'h0000;
    eu_reg_wr_vld = 1'b0;
    eu_load_op    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy),     32'h0);
    chk("idle_req",  32'(imem_req), 32'h0);
    run = 1'b1;

    // Reset during EXEC of an add: no write, no retire, refetch from 0
    do_instr(16'h1298, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (eu_opcode != 4'h0) seen = 1'b1;
    end
    chk("exec_seen", 32'(seen), 32'h1);
    #1;
    do_reset();

    do_instr(16'h1298, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // add r1 = r2 op r3
    do_instr(16'hE305, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // ld
    do_instr(16'hF000, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // st: no write even with wr_vld
    do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // nop
    do_instr(16'h5A5B, 3, 1'b1, 1'b0, 1'b0, 1'b0);  // ALU with 3-cycle fetch stall
    do_instr(16'hD123, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // ALU, no write, junk acks after
    do_instr(16'h2456, 1, 1'b1, 1'b1, 1'b0, 1'b0);  // run dropped mid-instruction
    repeat (6) @(posedge clk);
    #1;
    chk("drop_busy", 32'(busy),     32'h0);
    chk("drop_req",  32'(imem_req), 32'h0);
    chk("drop_ret",  32'(retired),  32'h7);
    chk("drop_sb",   32'(sb.size()), 32'h0);

    // PC wrap: 255 nops bring pc to FF, then fetches from FF and 00
    do_reset();
    run = 1'b1;
    for (int n = 0; n < 255; n++)
      do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("wrap_ret",  32'(retired),   32'h00FF);
    chk("wrap_addr", 32'(imem_addr), 32'h00FF);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (!busy) seen = 1'b1;
    end
    chk("end_idle", 32'(seen), 32'h1);
    repeat (2) @(posedge clk);
    chk("end_sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
